ps2_rx_fifo: RTL and testbench
==============================

# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver with a show-ahead byte FIFO, the board-level keyboard input path for the DE1-SoC top level. Samples the raw PS2_CLK/PS2_DAT pins in the CLOCK_50 domain, filters and frames 11-bit PS/2 frames, and checks parity. Valid scan-code bytes are queued for the consumer (CPU I/O port or display logic), with overflow and error reporting.

## Interface
Parameters:
- FIFO_AW, 3: FIFO address width; depth = 2**FIFO_AW bytes.
- FILTER_LEN, 4: consecutive equal samples required before the filtered PS/2 clock changes; range 1..15.
- TIMEOUT_CYCLES, 50000: idle CLOCK_50 cycles inside a frame before it is aborted (1 ms at 50 MHz).

Ports:
- CLOCK_50  in  1  system clock; sole clock of the block.
- rst  in  1  reset; asynchronous, active-high.
- ps2_clk  in  1  raw PS/2 clock pin (asynchronous).
- ps2_dat  in  1  raw PS/2 data pin (asynchronous).
- rd_en  in  1  pop request; honoured only while ready=1.
- clr_flags  in  1  synchronous clear of overflow and parity_err.
- data  out  8  FIFO head byte; 8'h00 while ready=0.
- ready  out  1  FIFO non-empty.
- count  out  FIFO_AW+1  bytes currently queued.
- overflow  out  1  sticky: a valid byte was dropped because the FIFO was full.
- parity_err  out  1  sticky: a frame was dropped on bad parity (macro-dependent).

## Operation
- Input path: two-flop synchroniser on both pins. Filtered clock clk_f changes only after FILTER_LEN consecutive synchronised samples differ from its current value. A falling edge of clk_f (fe) samples the synchronised data.
- Frame FSM, advancing only on fe:
  - IDLE: dat=0 -> DATA, bit counter cleared; dat=1 -> stay (spurious edge ignored).
  - DATA: shift dat in at bit 7 (LSB first on the wire); after the 8th bit -> PARITY.
  - PARITY: store bit -> STOP.
  - STOP: dat=1 and parity good -> push byte; otherwise drop. Always -> IDLE.
- Parity good means odd parity: XOR of 8 data bits and parity bit equals 1.
- Watchdog: counter cleared on every fe and in IDLE; reaching TIMEOUT_CYCLES in any non-IDLE state -> IDLE, partial byte discarded, no flag set.
- FIFO: circular buffer with FIFO_AW-bit pointers wrapping modulo depth.
  - Push while count < depth: write and increment.
  - Push while full, no pop: byte dropped, overflow set.
  - Push and pop in the same cycle while full: both succeed, count unchanged, overflow not set.
  - Push while empty with rd_en=1: rd_en ignored; push succeeds.
  - rd_en while empty: no effect.
- data is mem[rd_ptr] combinationally (show-ahead); it is valid whenever ready=1.
- clr_flags clears both sticky flags; a flag event in the same cycle wins (flag stays 1).
- Reset mid-frame or with bytes queued: FSM -> IDLE, pointers and count to 0, all sticky flags 0. Queued data is lost.

## Timing
- Reset values: data=8'h00, ready=0, count=0, overflow=0, parity_err=0. clk_f resets to 1.
- clk_f falls FILTER_LEN+2 cycles after a clean raw ps2_clk fall.
- fe is asserted for exactly one cycle after clk_f falls.
- The push is registered in the fe cycle of the stop bit. count, ready and data update on the next edge: FILTER_LEN+4 cycles after the raw stop-bit clock fall.
- A pop is registered: count, ready and data change on the edge after a cycle with rd_en=1 and ready=1.
- Throughput: one byte per frame; PS/2 rates of 10-16.7 kHz are far below FIFO bandwidth.

## Configuration
- PS2_PARITY_CHECK_EN defined:
  - A bad-parity frame is dropped and sets parity_err.
  - A bad stop bit drops the frame without setting a flag.
- PS2_PARITY_CHECK_EN undefined:
  - The parity bit is sampled but ignored; any frame with stop=1 is pushed.
  - parity_err is tied to 0.

## Test plan
- Send frame 0x1C (A make), parity 0, stop 1, at 12.5 kHz -> ready=1, data=8'h1C, count=1 at FILTER_LEN+4 cycles after the stop-bit fall. Pulse rd_en -> ready=0, data=8'h00.
- Send 0xF0 then 0x1C back-to-back, no reads -> count=2. First pop gives 0xF0, second gives 0x1C.
- Depth 8: send 9 frames 0x01..0x09, no reads -> count=8, overflow=1, head 0x01. Time the 10th frame's push together with rd_en -> count stays 8, 0x0A queued last.
- Send 0x1C with parity 1 -> macro defined: count=0, parity_err=1. Macro undefined: count=1, data=8'h1C. Then pulse clr_flags -> parity_err=0.
- Send start plus 4 data bits, then hold the clock high for TIMEOUT_CYCLES+10 cycles, then a full 0x29 frame -> only 0x29 queued, count=1.
- Inject 2-cycle low glitches on ps2_clk with FILTER_LEN=4 -> no fe, FSM stays IDLE. Assert rst mid-frame with 3 bytes queued -> all outputs at reset values; the next full frame is received correctly.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin synchroniser, clock glitch filter, frame FSM and show-ahead byte FIFO.
// Define PS2_PARITY_CHECK_EN to drop bad-parity frames and report them on parity_err.
`timescale 1ns/1ps
module ps2_rx_fifo #(
  parameter int FIFO_AW        = 3,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic               CLOCK_50,
  input  logic               rst,
  input  logic               ps2_clk,
  input  logic               ps2_dat,
  input  logic               rd_en,
  input  logic               clr_flags,
  output logic [7:0]         data,
  output logic               ready,
  output logic [FIFO_AW:0]   count,
  output logic               overflow,
  output logic               parity_err
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]         FILT_LAST = 4'(FILTER_LEN - 1);
  localparam logic [TW-1:0]      TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = 1;
  localparam logic [FIFO_AW:0]   CNT_ONE   = 1;
  localparam logic [FIFO_AW:0]   CNT_FULL  = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0] clk_s_q, clk_s_d, dat_s_q, dat_s_d;
  logic [3:0] filt_cnt_q, filt_cnt_d;
  logic       clk_f_q, clk_f_d, fe_q, fe_d;
  logic       clk_s, dat_s;

  state_t        state_q;
  logic [2:0]    bit_cnt_q;
  logic [TW-1:0] tmo_q;
  logic          push_q, perr_ev_q;
  logic [7:0]    shift_q;
  logic          frame_push_w, frame_perr_w;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               ovf_q, ovf_d, perr_q, perr_d;
  logic               pop_w, wr_ok_w;

  assign clk_s = clk_s_q[1];
  assign dat_s = dat_s_q[1];

  // Synchroniser and clock filter: clk_f flips only after FILTER_LEN disagreeing samples.
  always_comb begin
    clk_s_d    = {clk_s_q[0], ps2_clk};
    dat_s_d    = {dat_s_q[0], ps2_dat};
    filt_cnt_d = filt_cnt_q;
    clk_f_d    = clk_f_q;
    fe_d       = 1'b0;
    if (clk_s == clk_f_q) begin
      filt_cnt_d = 4'd0;
    end else if (filt_cnt_q == FILT_LAST) begin
      filt_cnt_d = 4'd0;
      clk_f_d    = ~clk_f_q;
      fe_d       = clk_f_q;
    end else begin
      filt_cnt_d = filt_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      clk_s_q    <= 2'b11;
      dat_s_q    <= 2'b11;
      filt_cnt_q <= 4'd0;
      clk_f_q    <= 1'b1;
      fe_q       <= 1'b0;
    end else begin
      clk_s_q    <= clk_s_d;
      dat_s_q    <= dat_s_d;
      filt_cnt_q <= filt_cnt_d;
      clk_f_q    <= clk_f_d;
      fe_q       <= fe_d;
    end
  end

  // Frame acceptance at the stop bit; the parity bit only matters when checking is built in.
`ifdef PS2_PARITY_CHECK_EN
  logic par_q;
  always_ff @(posedge CLOCK_50) begin
    if (fe_q && state_q == S_PARITY) par_q <= dat_s;
  end
  assign frame_push_w = dat_s & (^{shift_q, par_q});
  assign frame_perr_w = ~(^{shift_q, par_q});
`else
  assign frame_push_w = dat_s;
  assign frame_perr_w = 1'b0;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (fe_q && state_q == S_DATA) shift_q <= {dat_s, shift_q[7:1]};
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 3'd0;
      tmo_q     <= '0;
      push_q    <= 1'b0;
      perr_ev_q <= 1'b0;
    end else begin
      push_q    <= 1'b0;
      perr_ev_q <= 1'b0;
      if (state_q == S_IDLE || fe_q) tmo_q <= '0;
      else                           tmo_q <= tmo_q + 1'b1;
      // A stalled frame returns to IDLE silently; the partial byte is simply abandoned.
      if (state_q != S_IDLE && !fe_q && tmo_q == TMO_LAST) begin
        state_q <= S_IDLE;
      end else if (fe_q) begin
        case (state_q)
          S_IDLE: begin
            if (!dat_s) begin
              state_q   <= S_DATA;
              bit_cnt_q <= 3'd0;
            end
          end
          S_DATA: begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
          end
          S_PARITY: state_q <= S_STOP;
          default: begin
            state_q   <= S_IDLE;
            push_q    <= frame_push_w;
            perr_ev_q <= frame_perr_w;
          end
        endcase
      end
    end
  end

  // FIFO: a full FIFO still accepts a push when the same cycle pops.
  always_comb begin
    pop_w   = rd_en & (count_q != '0);
    wr_ok_w = push_q & ((count_q != CNT_FULL) | pop_w);
    count_d = count_q;
    if (wr_ok_w && !pop_w)      count_d = count_q + CNT_ONE;
    else if (!wr_ok_w && pop_w) count_d = count_q - CNT_ONE;
    wr_ptr_d = wr_ok_w ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop_w   ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    ovf_d    = (ovf_q & ~clr_flags) | (push_q & ~wr_ok_w);
    perr_d   = (perr_q & ~clr_flags) | perr_ev_q;
  end

  always_ff @(posedge CLOCK_50) begin
    if (wr_ok_w) mem[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      perr_q   <= perr_d;
    end
  end

  assign ready      = (count_q != '0);
  assign data       = ready ? mem[rd_ptr_q] : 8'h00;
  assign count      = count_q;
  assign overflow   = ovf_q;
  assign parity_err = perr_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: vector table, corner-case sequences and a random run against a queue model.
`timescale 1ns/1ps
module tb_ps2_rx_fifo;

  localparam int AW    = 3;
  localparam int FL    = 4;
  localparam int TO    = 400;
  localparam int HALF  = 30;
  localparam int DEPTH = 1 << AW;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic          CLOCK_50 = 1'b0;
  logic          rst, ps2_clk, ps2_dat, rd_en, clr_flags;
  logic [7:0]    data;
  logic          ready, overflow, parity_err;
  logic [AW:0]   count;

  int total = 0;
  int bad   = 0;

  logic [7:0] model_q[$];
  bit         m_ovf, m_perr;

  typedef struct {
    logic [7:0] b;
    bit         flip;
    bit         stop;
    int         ecount;
    logic [7:0] edata;
    bit         eperr;
  } vec_t;
  vec_t vecs[7];

  ps2_rx_fifo #(.FIFO_AW(AW), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_50(CLOCK_50), .rst(rst), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .rd_en(rd_en), .clr_flags(clr_flags), .data(data), .ready(ready),
    .count(count), .overflow(overflow), .parity_err(parity_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " count"}, count, model_q.size());
    chk({tag, " ready"}, ready, model_q.size() != 0);
    chk({tag, " data"}, data, (model_q.size() != 0) ? model_q[0] : 8'h00);
    chk({tag, " overflow"}, overflow, m_ovf);
    chk({tag, " parity_err"}, parity_err, m_perr);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " data"}, data, 8'h00);
    chk({tag, " ready"}, ready, 1'b0);
    chk({tag, " count"}, count, 0);
    chk({tag, " overflow"}, overflow, 1'b0);
    chk({tag, " parity_err"}, parity_err, 1'b0);
  endtask

  // Frame outcome from the protocol rules: odd parity, stop must be 1.
  task automatic model_frame(input logic [7:0] b, input bit flip, input bit stop);
    bit par_good;
    par_good = !flip;
    if (PCHK && !par_good) m_perr = 1'b1;
    if (stop && (par_good || !PCHK)) begin
      if (model_q.size() == DEPTH) m_ovf = 1'b1;
      else model_q.push_back(b);
    end
  endtask

  task automatic send_bit(input bit v);
    ps2_dat = v;
    cyc(HALF);
    ps2_clk = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  // mode 0: plain; 1: check push latency on the stop bit; 2: pulse rd_en in the push cycle
  task automatic send_frame(input logic [7:0] b, input bit flip, input bit stop, input int mode);
    logic [10:0] bits;
    bits = {stop, (~^b) ^ flip, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_dat = bits[i];
      cyc(HALF);
      ps2_clk = 1'b0;
      if (i == 10 && mode == 1) begin
        cyc(FL + 3);
        chk("latency ready before", ready, 1'b0);
        cyc(1);
        chk("latency ready", ready, 1'b1);
        chk("latency data", data, b);
        chk("latency count", count, 1);
        cyc(HALF - FL - 4);
      end else if (i == 10 && mode == 2) begin
        cyc(FL + 3);
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
        cyc(HALF - FL - 4);
      end else begin
        cyc(HALF);
      end
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    cyc(2 * HALF);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
    if (model_q.size() != 0) void'(model_q.pop_front());
  endtask

  task automatic clear_flags();
    clr_flags = 1'b1;
    cyc(1);
    clr_flags = 1'b0;
    m_ovf  = 1'b0;
    m_perr = 1'b0;
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (model_q.size() != 0 && guard < 2 * DEPTH) begin
      chk({tag, " drain data"}, data, model_q[0]);
      pop();
      guard++;
    end
    chk_model({tag, " drained"});
  endtask

  initial begin
    logic [7:0] rb;
    int kind, npop;

    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1, 8'h1C, 1'b0};
    vecs[1] = '{8'hF0, 1'b0, 1'b1, 1, 8'hF0, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 1'b1, 1, 8'h00, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 1, 8'hFF, 1'b0};
    vecs[4] = '{8'h1C, 1'b1, 1'b1, PCHK ? 0 : 1, PCHK ? 8'h00 : 8'h1C, PCHK};
    vecs[5] = '{8'h55, 1'b0, 1'b0, 0, 8'h00, 1'b0};
    vecs[6] = '{8'hA5, 1'b0, 1'b1, 1, 8'hA5, 1'b0};

    rst = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1; rd_en = 1'b0; clr_flags = 1'b0;
    m_ovf = 1'b0; m_perr = 1'b0;
    cyc(5);
    chk_reset_vals("reset");
    rst = 1'b0;
    cyc(5);
    chk_reset_vals("post reset");

    send_frame(8'h1C, 1'b0, 1'b1, 1);
    model_frame(8'h1C, 1'b0, 1'b1);
    chk_model("first frame");
    pop();
    chk("pop ready", ready, 1'b0);
    chk("pop data", data, 8'h00);

    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].b, vecs[i].flip, vecs[i].stop, 0);
      model_frame(vecs[i].b, vecs[i].flip, vecs[i].stop);
      chk($sformatf("vec%0d count", i), count, vecs[i].ecount);
      chk($sformatf("vec%0d data", i), data, vecs[i].edata);
      chk($sformatf("vec%0d parity_err", i), parity_err, vecs[i].eperr);
      drain($sformatf("vec%0d", i));
      clear_flags();
    end

    send_frame(8'hF0, 1'b0, 1'b1, 0); model_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1, 0); model_frame(8'h1C, 1'b0, 1'b1);
    chk("b2b count", count, 2);
    chk("b2b first", data, 8'hF0);
    pop();
    chk("b2b second", data, 8'h1C);
    pop();
    chk_model("b2b empty");

    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 1'b0, 1'b1, 0);
      model_frame(8'(i), 1'b0, 1'b1);
    end
    chk_model("full");
    chk("full overflow", overflow, 1'b1);
    clear_flags();
    chk("ovf cleared", overflow, 1'b0);
    send_frame(8'h0A, 1'b0, 1'b1, 2);
    void'(model_q.pop_front());
    model_frame(8'h0A, 1'b0, 1'b1);
    chk_model("push+pop full");
    drain("full");

    send_frame(8'h1C, 1'b1, 1'b1, 0);
    model_frame(8'h1C, 1'b1, 1'b1);
    chk_model("bad parity");
    clear_flags();
    chk("parity cleared", parity_err, 1'b0);
    drain("bad parity");

    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    cyc(TO + 10);
    send_frame(8'h29, 1'b0, 1'b1, 0);
    model_frame(8'h29, 1'b0, 1'b1);
    chk_model("timeout");
    drain("timeout");

    ps2_dat = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ps2_clk = 1'b0;
      cyc(2);
      ps2_clk = 1'b1;
      cyc(10);
    end
    ps2_dat = 1'b1;
    cyc(10);
    send_frame(8'h3A, 1'b0, 1'b1, 0);
    model_frame(8'h3A, 1'b0, 1'b1);
    chk_model("glitch");
    drain("glitch");

    send_frame(8'h11, 1'b0, 1'b1, 0); model_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1, 0); model_frame(8'h22, 1'b0, 1'b1);
    send_frame(8'h33, 1'b0, 1'b1, 0); model_frame(8'h33, 1'b0, 1'b1);
    chk("pre-reset count", count, 3);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b1;
    cyc(2);
    chk_reset_vals("mid-frame reset");
    ps2_clk = 1'b1; ps2_dat = 1'b1;
    rst = 1'b0;
    model_q.delete();
    m_ovf = 1'b0; m_perr = 1'b0;
    cyc(5);
    send_frame(8'h44, 1'b0, 1'b1, 0);
    model_frame(8'h44, 1'b0, 1'b1);
    chk_model("after reset");

    for (int n = 0; n < 30; n++) begin
      rb   = 8'($urandom);
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        send_frame(rb, 1'b1, 1'b1, 0); model_frame(rb, 1'b1, 1'b1);
      end else if (kind == 1) begin
        send_frame(rb, 1'b0, 1'b0, 0); model_frame(rb, 1'b0, 1'b0);
      end else begin
        send_frame(rb, 1'b0, 1'b1, 0); model_frame(rb, 1'b0, 1'b1);
      end
      chk_model($sformatf("rand%0d", n));
      npop = $urandom_range(0, 2);
      for (int k = 0; k < npop; k++) pop();
      if ($urandom_range(0, 7) == 0) clear_flags();
      chk_model($sformatf("rand%0d post", n));
    end
    drain("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
